// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch slice: opcode constants,
// instruction field positions and the fetch state enumeration.
package mips_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_HALT  = 6'h3F;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next program counter selection: reset, redirect, sequential advance or hold,
// plus a one-cycle strobe when a redirect target is not word aligned.
module pc_next_sel
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              reset,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              advance,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic              misalign_strobe
);

    // Priority chain: reset, redirect, advance, hold.
    always_comb begin
        pc_next         = pc;
        misalign_strobe = 1'b0;
        if (reset) begin
            pc_next = RESET_PC;
        end else if (redirect_en) begin
            pc_next         = {redirect_pc[ADDR_W-1:2], 2'b00};
            misalign_strobe = (redirect_pc[1:0] != 2'b00);
        end else if (advance) begin
            pc_next = pc + ADDR_W'(4);
        end else begin
            pc_next = pc;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, reads instMemory combinationally and holds
// one fetched entry for decode behind a valid/ready handshake.
module inst_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]        HALT_OPCODE = OPC_HALT
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc_plus4,
    output logic              halted,
    output logic              misalign
);

    fetch_state_e      state_r;
    fetch_state_e      state_next_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic              wr_s;
    logic              halt_hit_s;
    logic              advance_s;
    logic              misalign_strobe_s;

    assign imem_addr  = pc_r;
    assign wr_s       = (state_r == ST_RUN) && (!out_valid || out_ready);
    assign halt_hit_s = (opcode_of(imem_instr) == HALT_OPCODE);
    // A fetched HALT is buffered but the PC stays on it.
    assign advance_s  = wr_s && !halt_hit_s;

    pc_next_sel #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_next_sel (
        .reset           (reset),
        .redirect_en     (redirect_en),
        .redirect_pc     (redirect_pc),
        .advance         (advance_s),
        .pc              (pc_r),
        .pc_next         (pc_next_s),
        .misalign_strobe (misalign_strobe_s)
    );

    // Fetch state transitions; redirect always returns to RUN.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (redirect_en) begin
                    state_next_s = ST_RUN;
                end else if (wr_s && halt_hit_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (redirect_en) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // State, PC and status flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_RUN;
            pc_r     <= RESET_PC;
            halted   <= 1'b0;
            misalign <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            pc_r     <= pc_next_s;
            halted   <= (state_next_s == ST_HALT);
            misalign <= misalign | misalign_strobe_s;
        end
    end

    // One-entry fetch buffer; a redirect flushes even a consumed entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_instr    <= 32'h0000_0000;
            out_pc       <= {ADDR_W{1'b0}};
            out_pc_plus4 <= {ADDR_W{1'b0}};
        end else if (redirect_en) begin
            out_valid <= 1'b0;
        end else if (wr_s) begin
            out_valid    <= 1'b1;
            out_instr    <= imem_instr;
            out_pc       <= pc_r;
            out_pc_plus4 <= pc_r + ADDR_W'(4);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule
